// File: rtl/serial_adder_if.sv
// Handshake and data bundle between a serial_adder and its requester.
// The overflow signal exists only when OVERFLOW_FLAG_EN is defined.
`default_nettype none

interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
`ifdef OVERFLOW_FLAG_EN
  logic             overflow;
`endif

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, carry
`ifdef OVERFLOW_FLAG_EN
    , input overflow
`endif
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, carry
`ifdef OVERFLOW_FLAG_EN
    , output overflow
`endif
  );
endinterface

`default_nettype wire

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder (one full-adder slice, LSB first) with start/busy/done handshake.
// Optional signed-overflow flag enabled by defining OVERFLOW_FLAG_EN.
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  serial_adder_if.slave  bus_io
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             c_q,     c_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             carry_q, carry_d;
`ifdef OVERFLOW_FLAG_EN
  logic             ovf_q,   ovf_d;
`endif

  logic bit_sum;
  logic bit_cout;
  logic last_bit;

  assign bit_sum  = a_q[0] ^ b_q[0] ^ c_q;
  assign bit_cout = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sum_d   = sum_q;
    carry_d = carry_q;
`ifdef OVERFLOW_FLAG_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (bus_io.start) begin
          a_d     = bus_io.a;
          b_d     = bus_io.b;
          c_d     = bus_io.cin;
          cnt_d   = '0;
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end

      ADD: begin
        // A's register doubles as the result register: sum bits enter at the
        // MSB as operand bits leave the LSB, so after WIDTH shifts it holds the sum.
        a_d   = {bit_sum, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        c_d   = bit_cout;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_bit) begin
          sum_d   = {bit_sum, a_q[WIDTH-1:1]};
          carry_d = bit_cout;
`ifdef OVERFLOW_FLAG_EN
          // c_q is the carry into the MSB on this final edge.
          ovf_d   = c_q ^ bit_cout;
`endif
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus_io.busy  = (state_q == ADD);
  assign bus_io.done  = (state_q == DONE);
  assign bus_io.sum   = sum_q;
  assign bus_io.carry = carry_q;
`ifdef OVERFLOW_FLAG_EN
  assign bus_io.overflow = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); overflow checks compile
// in only when OVERFLOW_FLAG_EN is defined.
`default_nettype none

module tb_serial_adder;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  serial_adder_if #(.WIDTH(W)) u_if ();

  serial_adder #(.WIDTH(W)) u_dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Waits (bounded) for done; returns edges elapsed counting the accepting edge.
  task automatic wait_done(input int first, output int edges, output int busy_cycles);
    edges       = first;
    busy_cycles = 0;
    while (!u_if.done && edges < 30) begin
      busy_cycles += int'(u_if.busy);
      tick();
      edges++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] exp_sum,
                        input logic exp_carry, input logic exp_ovf);
    int edges, busy_cycles;
    u_if.start = 1'b1; u_if.a = a; u_if.b = b; u_if.cin = cin;
    tick();
    u_if.start = 1'b0; u_if.a = '0; u_if.b = '0; u_if.cin = 1'b0;
    wait_done(1, edges, busy_cycles);
    check({tag, " latency"}, edges, 9);
    check({tag, " busy cycles"}, busy_cycles, 8);
    check({tag, " busy at done"}, u_if.busy, 1'b0);
    check({tag, " sum"}, u_if.sum, exp_sum);
    check({tag, " carry"}, u_if.carry, exp_carry);
`ifdef OVERFLOW_FLAG_EN
    check({tag, " overflow"}, u_if.overflow, exp_ovf);
`else
    if (exp_ovf === 1'bx) $display("note: %s", tag);
`endif
    tick();
    check({tag, " done one cycle"}, u_if.done, 1'b0);
    check({tag, " sum held"}, u_if.sum, exp_sum);
  endtask

  initial begin
    int edges, busy_cycles, bad, done_seen;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    u_if.start = 1'b0; u_if.a = '0; u_if.b = '0; u_if.cin = 1'b0;
    @(negedge clk);
    tick();
    rst = 1'b0;
    check("reset busy", u_if.busy, 1'b0);
    check("reset done", u_if.done, 1'b0);
    check("reset sum", u_if.sum, 8'h00);
    check("reset carry", u_if.carry, 1'b0);
`ifdef OVERFLOW_FLAG_EN
    check("reset overflow", u_if.overflow, 1'b0);
`endif

    run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    run_op("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("ff+ff+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("7f+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // Start during ADD must be ignored.
    u_if.start = 1'b1; u_if.a = 8'h12; u_if.b = 8'h34; u_if.cin = 1'b0;
    tick();
    u_if.start = 1'b0;
    tick(); tick();
    u_if.start = 1'b1; u_if.a = 8'hAA; u_if.b = 8'h55;
    tick();
    u_if.start = 1'b0;
    wait_done(4, edges, busy_cycles);
    check("ignore latency", edges, 9);
    check("ignore sum", u_if.sum, 8'h46);
    check("ignore carry", u_if.carry, 1'b0);
    tick();
    check("ignore no restart", u_if.busy, 1'b0);

    // Back-to-back with start held high through done.
    u_if.start = 1'b1; u_if.a = 8'h01; u_if.b = 8'h02; u_if.cin = 1'b0;
    tick();
    wait_done(1, edges, busy_cycles);
    check("b2b first sum", u_if.sum, 8'h03);
    u_if.a = 8'h10; u_if.b = 8'h20;
    tick();
    u_if.start = 1'b0;
    check("b2b no idle gap", u_if.busy, 1'b1);
    bad = 0;
    edges = 1;
    while (!u_if.done && edges < 30) begin
      if (u_if.sum !== 8'h03) bad++;
      tick();
      edges++;
    end
    check("b2b sum hold", bad, 0);
    check("b2b second latency", edges, 9);
    check("b2b second sum", u_if.sum, 8'h30);
    tick();

    // Reset on the 4th busy cycle aborts the operation.
    u_if.start = 1'b1; u_if.a = 8'hF0; u_if.b = 8'h0F; u_if.cin = 1'b0;
    tick();
    u_if.start = 1'b0;
    tick(); tick(); tick();
    check("abort busy before reset", u_if.busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", u_if.busy, 1'b0);
    check("abort sum", u_if.sum, 8'h00);
    check("abort carry", u_if.carry, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      done_seen += int'(u_if.done);
      tick();
    end
    check("abort no done", done_seen, 0);
    run_op("after abort", 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
